// File: rtl/checked_alu_pipe_if.sv
// Request/response bundle for checked_alu_pipe: operation request, result
// handshake and fault-status outputs.
interface checked_alu_pipe_if #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [4:0]       ctrl_ALUopcode;
  logic [SHW-1:0]   ctrl_shiftamt;
  logic [1:0]       ctrl_fault_inject;
  logic             ctrl_fault_sticky;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data_result;
  logic             isNotEqual;
  logic             isLessThan;
  logic             fault_detected;
  logic             fault_fatal;
  logic [1:0]       retry_count;
  logic [7:0]       fault_count;

  modport master (
    output in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           ctrl_fault_inject, ctrl_fault_sticky, out_ready,
    input  in_ready, out_valid, data_result, isNotEqual, isLessThan,
           fault_detected, fault_fatal, retry_count, fault_count
  );

  modport slave (
    input  in_valid, data_operandA, data_operandB, ctrl_ALUopcode, ctrl_shiftamt,
           ctrl_fault_inject, ctrl_fault_sticky, out_ready,
    output in_ready, out_valid, data_result, isNotEqual, isLessThan,
           fault_detected, fault_fatal, retry_count, fault_count
  );
endinterface

// File: rtl/checked_alu_pipe.sv
// Dual-execution ALU: a primary unit (with fault injection) and an independent
// checker unit run the same operation; mismatches trigger bounded retries.
module checked_alu_pipe #(
  parameter int WIDTH     = 32,
  parameter int SHW       = $clog2(WIDTH),
  parameter int MAX_RETRY = 2
) (
  input  logic          clock,
  input  logic          reset,
  checked_alu_pipe_if.slave bus
);

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_AND = 5'd2;
  localparam logic [4:0] OP_OR  = 5'd3;
  localparam logic [4:0] OP_SLL = 5'd4;
  localparam logic [4:0] OP_SRA = 5'd5;
  localparam logic [1:0] MAX_RC = 2'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIMARY,
    S_CHECK,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [4:0]       op_reg;
  logic [SHW-1:0]   sh_reg;
  logic [1:0]       inj_reg;
  logic             sticky_reg;

  logic [WIDTH-1:0] primary_reg;
  logic [WIDTH-1:0] checker_reg;
  logic             chk_ne_reg;
  logic             chk_lt_reg;

  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             ne_reg;
  logic             lt_reg;
  logic             fault_detected_reg;
  logic             fault_fatal_reg;
  logic [1:0]       retry_count_reg;
  logic [7:0]       fault_count_reg;

  logic [WIDTH-1:0] inj_mask;
  logic [WIDTH-1:0] primary_calc;
  logic [WIDTH-1:0] checker_calc;
  logic [WIDTH-1:0] chk_sum;
  logic [WIDTH-1:0] chk_diff;
  logic             chk_ovf;
  logic             chk_ne;
  logic             chk_lt;
  logic [WIDTH-1:0] chk_sll;
  logic [WIDTH-1:0] chk_sra;

  // Primary unit: injection only touches ADD/SUB, and only on attempt 0 unless sticky.
  always_comb begin
    inj_mask = '0;
    if ((op_reg == OP_ADD || op_reg == OP_SUB) &&
        (sticky_reg || retry_count_reg == 2'd0)) begin
      inj_mask[WIDTH/2] = inj_reg[0];
      inj_mask[WIDTH/8] = inj_reg[1];
    end
    primary_calc = '0;
    case (op_reg)
      OP_ADD:  primary_calc = (a_reg + b_reg) ^ inj_mask;
      OP_SUB:  primary_calc = (a_reg + ~b_reg + WIDTH'(1)) ^ inj_mask;
      OP_AND:  primary_calc = a_reg & b_reg;
      OP_OR:   primary_calc = a_reg | b_reg;
      OP_SLL:  primary_calc = a_reg << sh_reg;
      OP_SRA:  primary_calc = $signed(a_reg) >>> sh_reg;
      default: primary_calc = '0;
    endcase
  end

  // Checker shifts use a separately built logarithmic shifter.
  for (genvar gi = 0; gi < SHW; gi++) begin : g_shift
    localparam int D = 1 << gi;
    logic [WIDTH-1:0] sll_in;
    logic [WIDTH-1:0] sra_in;
    logic [WIDTH-1:0] sll_out;
    logic [WIDTH-1:0] sra_out;
    if (gi == 0) begin : g_first
      assign sll_in = a_reg;
      assign sra_in = a_reg;
    end else begin : g_next
      assign sll_in = g_shift[gi-1].sll_out;
      assign sra_in = g_shift[gi-1].sra_out;
    end
    assign sll_out = sh_reg[gi] ? {sll_in[WIDTH-1-D:0], {D{1'b0}}} : sll_in;
    assign sra_out = sh_reg[gi] ? {{D{sra_in[WIDTH-1]}}, sra_in[WIDTH-1:D]} : sra_in;
  end

  assign chk_sll  = g_shift[SHW-1].sll_out;
  assign chk_sra  = g_shift[SHW-1].sra_out;
  assign chk_sum  = a_reg + b_reg;
  assign chk_diff = a_reg - b_reg;
  assign chk_ovf  = (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (chk_diff[WIDTH-1] ^ a_reg[WIDTH-1]);
  assign chk_ne   = |chk_diff;
  assign chk_lt   = chk_diff[WIDTH-1] ^ chk_ovf;

  always_comb begin
    checker_calc = '0;
    case (op_reg)
      OP_ADD:  checker_calc = chk_sum;
      OP_SUB:  checker_calc = chk_diff;
      OP_AND:  checker_calc = ~(~a_reg | ~b_reg);
      OP_OR:   checker_calc = ~(~a_reg & ~b_reg);
      OP_SLL:  checker_calc = chk_sll;
      OP_SRA:  checker_calc = chk_sra;
      default: checker_calc = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg          <= S_IDLE;
      a_reg              <= '0;
      b_reg              <= '0;
      op_reg             <= '0;
      sh_reg             <= '0;
      inj_reg            <= '0;
      sticky_reg         <= 1'b0;
      primary_reg        <= '0;
      checker_reg        <= '0;
      chk_ne_reg         <= 1'b0;
      chk_lt_reg         <= 1'b0;
      in_ready_reg       <= 1'b1;
      out_valid_reg      <= 1'b0;
      result_reg         <= '0;
      ne_reg             <= 1'b0;
      lt_reg             <= 1'b0;
      fault_detected_reg <= 1'b0;
      fault_fatal_reg    <= 1'b0;
      retry_count_reg    <= 2'd0;
      fault_count_reg    <= 8'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg              <= bus.data_operandA;
            b_reg              <= bus.data_operandB;
            op_reg             <= bus.ctrl_ALUopcode;
            sh_reg             <= bus.ctrl_shiftamt;
            inj_reg            <= bus.ctrl_fault_inject;
            sticky_reg         <= bus.ctrl_fault_sticky;
            fault_detected_reg <= 1'b0;
            fault_fatal_reg    <= 1'b0;
            retry_count_reg    <= 2'd0;
            in_ready_reg       <= 1'b0;
            state_reg          <= S_PRIMARY;
          end
        end
        S_PRIMARY: begin
          primary_reg <= primary_calc;
          state_reg   <= S_CHECK;
        end
        S_CHECK: begin
          checker_reg <= checker_calc;
          chk_ne_reg  <= chk_ne;
          chk_lt_reg  <= chk_lt;
          state_reg   <= S_COMPARE;
        end
        S_COMPARE: begin
          if (primary_reg == checker_reg) begin
            result_reg    <= primary_reg;
            ne_reg        <= chk_ne_reg;
            lt_reg        <= chk_lt_reg;
            out_valid_reg <= 1'b1;
            state_reg     <= S_DONE;
          end else begin
            fault_detected_reg <= 1'b1;
            if (fault_count_reg != 8'hFF) begin
              fault_count_reg <= fault_count_reg + 8'd1;
            end
            if (retry_count_reg < MAX_RC) begin
              retry_count_reg <= retry_count_reg + 2'd1;
              state_reg       <= S_PRIMARY;
            end else begin
              // Retries exhausted: trust the checker, which never sees injection.
              fault_fatal_reg <= 1'b1;
              result_reg      <= checker_reg;
              ne_reg          <= chk_ne_reg;
              lt_reg          <= chk_lt_reg;
              out_valid_reg   <= 1'b1;
              state_reg       <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready       = in_ready_reg;
  assign bus.out_valid      = out_valid_reg;
  assign bus.data_result    = result_reg;
  assign bus.isNotEqual     = ne_reg;
  assign bus.isLessThan     = lt_reg;
  assign bus.fault_detected = fault_detected_reg;
  assign bus.fault_fatal    = fault_fatal_reg;
  assign bus.retry_count    = retry_count_reg;
  assign bus.fault_count    = fault_count_reg;

endmodule

// File: tb/tb_checked_alu_pipe.sv
// Directed-vector bench for checked_alu_pipe (WIDTH=32, MAX_RETRY=2) with
// hand-written backpressure and mid-operation reset sequences.
module tb_checked_alu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  checked_alu_pipe_if #(.WIDTH(32), .SHW(5)) bus ();
  checked_alu_pipe #(.WIDTH(32), .SHW(5), .MAX_RETRY(2)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [1:0]  inj;
    logic        sticky;
    logic [31:0] res;
    logic        ne;
    logic        lt;
    logic        fd;
    logic        ff;
    logic [1:0]  rc;
    int          lat;
    int          dfc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  // Called #1 after a rising edge while idle; returns edges from accept to out_valid.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, input logic [1:0] inj, input logic sticky,
                        output int lat);
    bus.in_valid          = 1'b1;
    bus.ctrl_ALUopcode    = op;
    bus.data_operandA     = a;
    bus.data_operandB     = b;
    bus.ctrl_shiftamt     = sh;
    bus.ctrl_fault_inject = inj;
    bus.ctrl_fault_sticky = sticky;
    @(posedge clk);
    #1;
    // Scramble inputs after accept: the operation in flight must not see them.
    bus.in_valid          = 1'b0;
    bus.ctrl_ALUopcode    = op + 5'd1;
    bus.data_operandA     = ~a;
    bus.data_operandB     = a ^ b ^ 32'h5A5A_5A5A;
    bus.ctrl_shiftamt     = sh + 5'd1;
    bus.ctrl_fault_inject = ~inj;
    bus.ctrl_fault_sticky = ~sticky;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    check({tag, " data_result"}, bus.data_result, 32'd0);
    check({tag, " isNotEqual"}, 32'(bus.isNotEqual), 32'd0);
    check({tag, " isLessThan"}, 32'(bus.isLessThan), 32'd0);
    check({tag, " fault_detected"}, 32'(bus.fault_detected), 32'd0);
    check({tag, " fault_fatal"}, 32'(bus.fault_fatal), 32'd0);
    check({tag, " retry_count"}, 32'(bus.retry_count), 32'd0);
    check({tag, " fault_count"}, 32'(bus.fault_count), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [7:0]  fc0;
    string       tag;

    rst                   = 1'b1;
    bus.in_valid          = 1'b0;
    bus.out_ready         = 1'b0;
    bus.data_operandA     = '0;
    bus.data_operandB     = '0;
    bus.ctrl_ALUopcode    = '0;
    bus.ctrl_shiftamt     = '0;
    bus.ctrl_fault_inject = '0;
    bus.ctrl_fault_sticky = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;

    //            op     a             b             sh     inj    st    res           ne    lt    fd    ff    rc    lat dfc
    vecs[0]  = '{5'd0, 32'd5,        32'd7,        5'd0,  2'b00, 1'b0, 32'd12,       1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[1]  = '{5'd1, 32'd3,        32'd3,        5'd0,  2'b01, 1'b0, 32'd0,        1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 6, 1};
    vecs[2]  = '{5'd0, 32'd1,        32'd1,        5'd0,  2'b11, 1'b1, 32'd2,        1'b0, 1'b0, 1'b1, 1'b1, 2'd2, 9, 3};
    vecs[3]  = '{5'd2, 32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  2'b11, 1'b1, 32'hF000F000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[4]  = '{5'd5, 32'h80000000, 32'd0,        5'd4,  2'b00, 1'b0, 32'hF8000000, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[5]  = '{5'd4, 32'd1,        32'd1,        5'd31, 2'b00, 1'b0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[6]  = '{5'd3, 32'h0F,       32'hF0,       5'd0,  2'b00, 1'b0, 32'hFF,       1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[7]  = '{5'd1, 32'h80000000, 32'd1,        5'd0,  2'b00, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[8]  = '{5'd0, 32'hFFFFFFFF, 32'd1,        5'd0,  2'b00, 1'b0, 32'd0,        1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[9]  = '{5'd7, 32'd5,        32'd5,        5'd3,  2'b11, 1'b1, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[10] = '{5'd1, 32'h7FFFFFFF, 32'hFFFFFFFF, 5'd0,  2'b00, 1'b0, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[11] = '{5'd0, 32'd10,       32'd20,       5'd0,  2'b10, 1'b0, 32'd30,       1'b1, 1'b1, 1'b1, 1'b0, 2'd1, 6, 1};
    vecs[12] = '{5'd5, 32'h7FFFFFF0, 32'd0,        5'd31, 2'b00, 1'b0, 32'd0,        1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 3, 0};
    vecs[13] = '{5'd4, 32'h12345678, 32'h12345678, 5'd0,  2'b00, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3, 0};

    for (int i = 0; i < 14; i++) begin
      fc0 = bus.fault_count;
      tag = $sformatf("v%0d", i);
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].inj, vecs[i].sticky, lat);
      if (lat < 0) begin
        checks++;
        failures++;
        $display("FAIL %s timeout: out_valid not seen within 40 edges", tag);
      end else begin
        check({tag, " latency"}, 32'(lat), 32'(vecs[i].lat));
        check({tag, " result"}, bus.data_result, vecs[i].res);
        check({tag, " isNotEqual"}, 32'(bus.isNotEqual), 32'(vecs[i].ne));
        check({tag, " isLessThan"}, 32'(bus.isLessThan), 32'(vecs[i].lt));
        check({tag, " fault_detected"}, 32'(bus.fault_detected), 32'(vecs[i].fd));
        check({tag, " fault_fatal"}, 32'(bus.fault_fatal), 32'(vecs[i].ff));
        check({tag, " retry_count"}, 32'(bus.retry_count), 32'(vecs[i].rc));
        check({tag, " fault_count delta"}, 32'(bus.fault_count) - 32'(fc0), 32'(vecs[i].dfc));
        release_out();
        check({tag, " out_valid dropped"}, 32'(bus.out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(bus.in_ready), 32'd1);
      end
    end
    check("total fault_count", 32'(bus.fault_count), 32'd5);

    // Backpressure: hold out_ready low in DONE while in_valid pokes at the block.
    run_op(5'd0, 32'd2, 32'd3, 5'd0, 2'b00, 1'b0, lat);
    check("bp latency", 32'(lat), 32'd3);
    bus.in_valid      = 1'b1;
    bus.data_operandA = 32'd100;
    bus.data_operandB = 32'd200;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      tag = $sformatf("bp cyc%0d", j);
      check({tag, " out_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, " result"}, bus.data_result, 32'd5);
      check({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
    end
    release_out();
    bus.in_valid = 1'b0;
    check("bp release out_valid", 32'(bus.out_valid), 32'd0);
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp no stray accept", 32'(bus.in_ready), 32'd1);

    // Reset while the operation sits in CHECK discards it entirely.
    bus.in_valid          = 1'b1;
    bus.ctrl_ALUopcode    = 5'd0;
    bus.data_operandA     = 32'd1;
    bus.data_operandB     = 32'd1;
    bus.ctrl_fault_inject = 2'b11;
    bus.ctrl_fault_sticky = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_values("rst in CHECK");
    repeat (4) @(posedge clk);
    #1;
    check("post-reset idle out_valid", 32'(bus.out_valid), 32'd0);
    run_op(5'd0, 32'd4, 32'd4, 5'd0, 2'b00, 1'b0, lat);
    check("post-reset latency", 32'(lat), 32'd3);
    check("post-reset result", bus.data_result, 32'd8);
    check("post-reset isNotEqual", 32'(bus.isNotEqual), 32'd0);
    check("post-reset fault_count", 32'(bus.fault_count), 32'd0);
    release_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/checked_alu_pipe.md
CHECKED_ALU_PIPE -- requirements
Module: checked_alu_pipe

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width (power of 2, >= 8).
REQ-002 Parameter: SHW, default log2(WIDTH) = 5, shift-amount width.
REQ-003 Parameter: MAX_RETRY, default 2, re-executions allowed after a mismatch before the fault is declared fatal.
REQ-004 Port: clock  in  1  single rising-edge clock; reset is synchronous and active-high.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  operation request.
REQ-007 Port: in_ready  out  1  block can accept; high only in IDLE.
REQ-008 Port: data_operandA, data_operandB  in  WIDTH  operands.
REQ-009 Port: ctrl_ALUopcode  in  5  0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLL(A), 5=SRA(A); others illegal.
REQ-010 Port: ctrl_shiftamt  in  SHW  shift amount for SLL/SRA.
REQ-011 Port: ctrl_fault_inject  in  2  bit0 flips primary adder sum bit WIDTH/2; bit1 flips sum bit WIDTH/8.
REQ-012 Port: ctrl_fault_sticky  in  1  1 = injection applied on every attempt; 0 = first attempt only.
REQ-013 Port: out_valid  out  1  result available.
REQ-014 Port: out_ready  in  1  consumer accepts result.
REQ-015 Port: data_result  out  WIDTH  final result.
REQ-016 Port: isNotEqual, isLessThan  out  1 each  A != B; signed A < B.
REQ-017 Port: fault_detected  out  1  at least one mismatch occurred for this operation.
REQ-018 Port: fault_fatal  out  1  mismatch persisted after MAX_RETRY retries.
REQ-019 Port: retry_count  out  2  retries used for this operation.
REQ-020 Port: fault_count  out  8  saturating total of mismatches since reset.

Function
REQ-021 All inputs sampled on the accepting edge (in_valid & in_ready) shall be latched; later input changes shall not affect the operation in flight.
REQ-022 FSM states: IDLE -> PRIMARY -> CHECK -> COMPARE -> DONE -> IDLE; one edge per transition.
REQ-023 PRIMARY shall register the primary-unit result, with the latched injection XORed into the sum for ADD/SUB only.
REQ-024 CHECK shall register an independent checker-unit result for the same operation, never subject to injection.
REQ-025 COMPARE on match shall go to DONE with data_result = primary result.
REQ-026 COMPARE on mismatch with retry_count < MAX_RETRY shall increment retry_count, set fault_detected, and return to PRIMARY.
REQ-027 COMPARE on mismatch with retry_count == MAX_RETRY shall go to DONE with fault_fatal=1, fault_detected=1, and data_result = checker result.
REQ-028 Every mismatch shall increment fault_count, saturating at 255.
REQ-029 Latency from the accepting edge to out_valid high shall be 3 + 3*retry_count edges.
REQ-030 Non-sticky injection shall apply only to attempt 0; retries shall run fault-free.
REQ-031 ADD/SUB shall wrap modulo 2^WIDTH; SUB = A + ~B + 1; SLL shall zero-fill; SRA shall sign-fill; shift amount range is 0..WIDTH-1.
REQ-032 Illegal opcodes shall yield data_result=0 with no fault.
REQ-033 isNotEqual/isLessThan shall come from the checker A-B path regardless of opcode, including overflow-correct signed compare.
REQ-034 In DONE, all outputs shall hold stable until out_valid & out_ready; then go to IDLE and drop out_valid on that edge.
REQ-035 in_ready shall be 0 outside IDLE; requests are not queued, and at most one operation is in flight.

Reset
REQ-036 reset shall force IDLE on the next edge from any state and discard any in-flight operation.
REQ-037 On reset: out_valid=0, in_ready=1, data_result=0, isNotEqual=0, isLessThan=0, fault_detected=0, fault_fatal=0, retry_count=0, fault_count=0.
REQ-038 reset shall take priority over a simultaneous accept or output handshake.
REQ-039 fault_detected, fault_fatal, and retry_count shall clear on each new accept; fault_count shall clear only on reset.

Verification (WIDTH=32, MAX_RETRY=2)
REQ-040 ADD 5+7, inject=00 -> out_valid 3 edges after accept; result 12, isLessThan=1, isNotEqual=1, fault_detected=0, retry_count=0.
REQ-041 SUB 3-3, inject=01, sticky=0 -> one mismatch (primary 0x00010000), retry; out_valid after 6 edges; result 0, isNotEqual=0, fault_detected=1, retry_count=1, fault_fatal=0, fault_count=1.
REQ-042 ADD 1+1, inject=11, sticky=1 -> three mismatches; out_valid after 9 edges; result 2, fault_fatal=1, retry_count=2, fault_count increases by 3.
REQ-043 AND 0xF0F0F0F0 & 0xFF00FF00, inject=11, sticky=1 -> result 0xF000F000, no fault, latency 3; SRA A=0x80000000, shamt=4 -> 0xF8000000.
REQ-044 out_ready held low 5 cycles in DONE -> outputs stable, in_ready=0, in_valid ignored; a then-raised out_ready returns the block to IDLE.
REQ-045 reset asserted in CHECK -> next edge IDLE with all outputs at reset values; a following ADD completes normally.
